// File: rtl/nnet_fifo_packetizer.sv
// nnet_fifo_packetizer
// Bridges an HLS ap_fifo result port onto a 32-bit AXI-stream. Samples are
// buffered in a small FIFO whose last slot is the AXI output register, then
// zero-extended to 32 bits. Because the HLS core has no tlast, packets are
// re-framed here from a programmable sample count.
module nnet_fifo_packetizer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_AWIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [15:0]           pkt_size,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  output logic                  full_n,
  output logic [31:0]           o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic [31:0]           pkt_count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AWIDTH;
  // The output register counts as one entry, so the RAM holds DEPTH-1.
  localparam int unsigned STORE = DEPTH - 1;
  localparam logic [FIFO_AWIDTH:0]   DEPTH_C  = (FIFO_AWIDTH + 1)'(DEPTH);
  localparam logic [FIFO_AWIDTH-1:0] LAST_IDX = FIFO_AWIDTH'(STORE - 1);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  // Storage FIFO
  logic [DATA_WIDTH-1:0]  mem [STORE];
  logic [FIFO_AWIDTH-1:0] wr_ptr;
  logic [FIFO_AWIDTH-1:0] rd_ptr;
  logic [FIFO_AWIDTH:0]   sto_cnt;
  logic [FIFO_AWIDTH:0]   sto_cnt_next;

  // Output register
  logic                  out_valid;
  logic                  out_valid_next;
  logic [DATA_WIDTH-1:0] out_data;

  // Handshake / occupancy
  logic                 wr_acc;
  logic                 hs;
  logic                 sto_pop;
  logic [FIFO_AWIDTH:0] count_next;

  // Framing
  state_t      state_q;
  state_t      state_d;
  logic [15:0] beat_cnt;
  logic [15:0] cur_size;
  logic [15:0] eff_size;
  logic [15:0] size_sel;
  logic        last_beat;

  // Accept/handshake decode and next occupancy of storage plus output register
  always_comb begin
    wr_acc         = write && full_n;
    hs             = out_valid && o_tready;
    sto_pop        = (sto_cnt != '0) && (!out_valid || hs);
    sto_cnt_next   = sto_cnt + (FIFO_AWIDTH + 1)'(wr_acc) - (FIFO_AWIDTH + 1)'(sto_pop);
    out_valid_next = sto_pop || (out_valid && !hs);
    count_next     = sto_cnt_next + (FIFO_AWIDTH + 1)'(out_valid_next);
  end

  // Storage pointers and fill level; pointers wrap at DEPTH-1 entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sto_cnt <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      sto_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (sto_pop) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      sto_cnt <= sto_cnt_next;
    end
  end

  // Sample RAM, no reset needed: contents are qualified by sto_cnt
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) mem[wr_ptr] <= din;
  end

  // Output register: refills from storage when empty or on a handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= out_valid_next;
      if (sto_pop) out_data <= mem[rd_ptr];
    end
  end

  // Registered not-full flag, low during reset and for one cycle after clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_n <= 1'b0;
    end else if (clear) begin
      full_n <= 1'b0;
    end else begin
      full_n <= (count_next < DEPTH_C);
    end
  end

  // Sticky overflow on a write attempted while full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (write && !full_n) begin
      overflow <= 1'b1;
    end
  end

  // Framing FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM next state: leave IDLE on a non-final first beat, return on tlast
  always_comb begin
    state_d = state_q;
    if (hs) begin
      state_d = last_beat ? IDLE : IN_PKT;
    end
  end

  // Framing FSM outputs: tlast against live size in IDLE, latched size otherwise
  always_comb begin
    eff_size  = (pkt_size == '0) ? 16'd1 : pkt_size;
    size_sel  = (state_q == IDLE) ? eff_size : cur_size;
    last_beat = (beat_cnt == size_sel - 16'd1);
    o_tlast   = out_valid && last_beat;
  end

  // Beat counter, latched packet size and completed-packet counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      cur_size  <= 16'd1;
      pkt_count <= '0;
    end else if (clear) begin
      beat_cnt  <= '0;
      cur_size  <= 16'd1;
      pkt_count <= '0;
    end else if (hs) begin
      if (state_q == IDLE) cur_size <= eff_size;
      if (last_beat) begin
        beat_cnt  <= '0;
        pkt_count <= pkt_count + 32'd1;
      end else begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  assign o_tvalid = out_valid;
  assign o_tdata  = 32'(out_data);

endmodule

// File: tb/tb_nnet_fifo_packetizer.sv
// Testbench for nnet_fifo_packetizer: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based packet model.
module tb_nnet_fifo_packetizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] pkt_size = 16'd0;
  logic [15:0] din = 16'd0;
  logic        write = 1'b0;
  logic        full_n;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b0;
  logic [31:0] pkt_count;
  logic        overflow;

  nnet_fifo_packetizer #(
    .DATA_WIDTH (16),
    .FIFO_AWIDTH(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .pkt_size (pkt_size),
    .din      (din),
    .write    (write),
    .full_n   (full_n),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .pkt_count(pkt_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: samples held in the block, each tagged with the edge
  // that accepted it; a sample is visible once a later edge has passed.
  typedef struct {
    logic [15:0] d;
    int unsigned e;
  } ent_t;

  ent_t        q[$];
  int unsigned edge_no = 0;
  bit          fulln_m = 1'b0;
  int unsigned beat_m = 0;
  int unsigned len_m = 1;
  logic [31:0] pc_m = '0;
  bit          ovf_m = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned run_len;
  int unsigned max_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tvalid();
    return (q.size() > 0) && (q[0].e < edge_no);
  endfunction

  function automatic bit m_tlast();
    int unsigned len;
    if (!m_tvalid()) return 1'b0;
    len = (beat_m == 0) ? ((pkt_size == 16'd0) ? 1 : int'(pkt_size)) : len_m;
    return beat_m == len - 1;
  endfunction

  task automatic model_flush();
    q.delete();
    beat_m  = 0;
    len_m   = 1;
    pc_m    = '0;
    ovf_m   = 1'b0;
    fulln_m = 1'b0;
  endtask

  // One clock cycle: drive, advance the model across the edge, check.
  task automatic step(input bit wr, input logic [15:0] d, input bit rdy,
                      input logic [15:0] ps, input bit clr);
    bit          acc, ovs, hs, tl, stall, same_ps;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_data = o_tdata;
    prev_last = o_tlast;
    same_ps   = (pkt_size == ps);
    write     = wr;
    din       = d;
    o_tready  = rdy;
    pkt_size  = ps;
    clear     = clr;
    hs    = m_tvalid() && rdy;
    tl    = m_tlast();
    acc   = wr && fulln_m;
    ovs   = wr && !fulln_m;
    stall = m_tvalid() && !rdy && !clr;
    @(posedge clk);
    edge_no++;
    if (clr) begin
      model_flush();
    end else begin
      if (hs) begin
        if (beat_m == 0) len_m = (ps == 16'd0) ? 1 : int'(ps);
        void'(q.pop_front());
        if (tl) begin
          beat_m = 0;
          pc_m   = pc_m + 32'd1;
        end else begin
          beat_m++;
        end
      end
      if (acc) q.push_back('{d: d, e: edge_no});
      if (ovs) ovf_m = 1'b1;
      fulln_m = (q.size() < 16);
    end
    @(negedge clk);
    check_eq("tvalid", {31'd0, o_tvalid}, {31'd0, m_tvalid()});
    check_eq("full_n", {31'd0, full_n}, {31'd0, fulln_m});
    check_eq("pkt_count", pkt_count, pc_m);
    check_eq("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    if (m_tvalid()) begin
      check_eq("tdata", o_tdata, {16'd0, q[0].d});
      check_eq("tlast", {31'd0, o_tlast}, {31'd0, m_tlast()});
    end
    if (stall) begin
      check_eq("tdata_hold", o_tdata, prev_data);
      if (same_ps) check_eq("tlast_hold", {31'd0, o_tlast}, {31'd0, prev_last});
    end
    if (o_tvalid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  // Assert reset between clock edges; outputs must drop without an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n  = 1'b0;
    write    = 1'b0;
    clear    = 1'b0;
    o_tready = 1'b0;
    #1;
    check_eq("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    check_eq("rst_tlast", {31'd0, o_tlast}, 32'd0);
    check_eq("rst_tdata", o_tdata, 32'd0);
    check_eq("rst_full_n", {31'd0, full_n}, 32'd0);
    check_eq("rst_pkt_count", pkt_count, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    model_flush();
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic idle(input int unsigned n, input bit rdy, input logic [15:0] ps);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'd0, rdy, ps, 1'b0);
  endtask

  initial begin
    do_reset();
    step(1'b0, 16'd0, 1'b1, 16'd4, 1'b0);

    // Basic framing, size 4
    for (int unsigned i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b1, 16'd4, 1'b0);
    idle(4, 1'b1, 16'd4);
    check_eq("basic_pkt_count", pkt_count, 32'd2);
    check_eq("basic_overflow", {31'd0, overflow}, 32'd0);

    // Backpressure and overflow
    for (int unsigned i = 0; i < 20; i++) step(1'b1, 16'(16'h0010 + i), 1'b0, 16'd4, 1'b0);
    check_eq("bp_full_n", {31'd0, full_n}, 32'd0);
    check_eq("bp_overflow", {31'd0, overflow}, 32'd1);
    idle(20, 1'b1, 16'd4);
    check_eq("bp_full_n_back", {31'd0, full_n}, 32'd1);
    check_eq("bp_pkt_count", pkt_count, 32'd6);

    // Mid-packet size change
    step(1'b0, 16'd0, 1'b1, 16'd3, 1'b1);
    step(1'b0, 16'd0, 1'b1, 16'd3, 1'b0);
    step(1'b1, 16'h0101, 1'b1, 16'd3, 1'b0);
    step(1'b1, 16'h0102, 1'b1, 16'd3, 1'b0);
    step(1'b1, 16'h0103, 1'b1, 16'd3, 1'b0);
    for (int unsigned i = 4; i <= 8; i++) step(1'b1, 16'(16'h0100 + i), 1'b1, 16'd5, 1'b0);
    idle(4, 1'b1, 16'd5);
    check_eq("resize_pkt_count", pkt_count, 32'd2);

    // Zero size: every beat is a packet
    step(1'b0, 16'd0, 1'b1, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 16'd0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'(16'h0200 + i), 1'b1, 16'd0, 1'b0);
    idle(3, 1'b1, 16'd0);
    check_eq("zero_pkt_count", pkt_count, 32'd3);

    // Clear mid-packet, then a fresh size-8 packet
    step(1'b0, 16'd0, 1'b1, 16'd8, 1'b1);
    step(1'b0, 16'd0, 1'b1, 16'd8, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'(16'h0300 + i), 1'b1, 16'd8, 1'b0);
    idle(2, 1'b1, 16'd8);
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 16'(16'h0310 + i), 1'b0, 16'd8, 1'b0);
    step(1'b0, 16'd0, 1'b0, 16'd8, 1'b1);
    check_eq("clr_tvalid", {31'd0, o_tvalid}, 32'd0);
    check_eq("clr_pkt_count", pkt_count, 32'd0);
    step(1'b0, 16'd0, 1'b1, 16'd8, 1'b0);
    for (int unsigned i = 0; i < 8; i++) step(1'b1, 16'(16'h0320 + i), 1'b1, 16'd8, 1'b0);
    idle(3, 1'b1, 16'd8);
    check_eq("clr_fresh_pkt", pkt_count, 32'd1);

    // Same with asynchronous reset mid-packet
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 16'(16'h0400 + i), 1'b1, 16'd8, 1'b0);
    idle(2, 1'b1, 16'd8);
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 16'(16'h0410 + i), 1'b0, 16'd8, 1'b0);
    do_reset();
    step(1'b0, 16'd0, 1'b1, 16'd8, 1'b0);
    for (int unsigned i = 0; i < 8; i++) step(1'b1, 16'(16'h0420 + i), 1'b1, 16'd8, 1'b0);
    idle(3, 1'b1, 16'd8);
    check_eq("rst_fresh_pkt", pkt_count, 32'd1);

    // Throughput: 64 back-to-back beats, no bubbles
    step(1'b0, 16'd0, 1'b1, 16'd16, 1'b1);
    step(1'b0, 16'd0, 1'b1, 16'd16, 1'b0);
    run_len = 0;
    max_run = 0;
    for (int unsigned i = 0; i < 64; i++) step(1'b1, 16'(16'h0500 + i), 1'b1, 16'd16, 1'b0);
    idle(3, 1'b1, 16'd16);
    check_eq("tput_run", max_run, 32'd64);
    check_eq("tput_pkt_count", pkt_count, 32'd4);

    // Randomized traffic with ready gaps, occasional clear and size changes
    for (int unsigned blk = 0; blk < 4; blk++) begin
      logic [15:0] ps;
      ps = 16'($urandom_range(0, 6));
      for (int unsigned i = 0; i < 150; i++) begin
        step($urandom_range(0, 9) < 7, 16'($urandom), 1'($urandom_range(0, 1)), ps,
             $urandom_range(0, 99) == 0);
      end
    end
    idle(20, 1'b1, 16'd3);
    check_eq("rand_drained", {31'd0, o_tvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/nnet_fifo_packetizer.md
# nnet_fifo_packetizer

Output-side bridge between an HLS neural-net core's `ap_fifo` result port (`din`/`full_n`/`write`) and the 32-bit AXI-stream data input of `axi_wrapper`. It buffers result samples in a small FIFO and zero-extends them to 32 bits. Because the HLS core does not propagate tlast, the block regenerates tlast by framing the stream into packets of a programmable sample count. It replaces the ad-hoc tie-offs currently used on the HLS result path.

## Interface
Parameters:
- `DATA_WIDTH`, 16: HLS result sample width (≤32).
- `FIFO_AWIDTH`, 4: log2 of buffer depth; DEPTH = 2^FIFO_AWIDTH = 16 entries, output register included.

Ports (single clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `clear` in 1: synchronous flush, same effect as reset.
- `pkt_size` in 16: samples per output packet, sampled at each packet's first beat.
- `din` in DATA_WIDTH: HLS result sample.
- `write` in 1: HLS write strobe.
- `full_n` out 1: not-full indication to HLS.
- `o_tdata` out 32: `{zeros, sample}`.
- `o_tlast` out 1: last beat of packet.
- `o_tvalid` out 1: AXI valid.
- `o_tready` in 1: AXI ready.
- `pkt_count` out 32: completed packets, wraps at 2^32.
- `overflow` out 1: sticky, set when `write` is high while `full_n` is low.

## Operation
- Write acceptance: a sample is accepted when `write && full_n` at a rising edge.
  - `write` with `full_n=0` drops the sample and sets `overflow`. Overflow stays set until reset or `clear`.
- Occupancy `count` (0..DEPTH) includes the output register.
  - `full_n` is registered: `full_n <= (count_next < DEPTH)`.
  - A read freeing a slot in cycle N raises `full_n` after edge N; a write in cycle N is not admitted by a same-cycle read.
- Output stage: a single register holding the head sample.
  - It loads from the FIFO when it is empty or when a handshake (`o_tvalid && o_tready`) completes.
  - `o_tdata`/`o_tlast` hold stable while `o_tvalid && !o_tready`.
- Framing FSM:
  - IDLE: no beat of the current packet has been emitted, `beat_cnt=0`.
  - On the first handshake, latch `cur_size = (pkt_size==0) ? 1 : pkt_size` and go to IN_PKT.
  - IN_PKT: each handshake increments `beat_cnt`.
  - `o_tlast = (beat_cnt == cur_size-1)`, evaluated against the latched size. In IDLE it is evaluated against the live `pkt_size`, so a 1-sample packet gets tlast on its only beat.
  - A handshake with tlast returns to IDLE, clears `beat_cnt`, and increments `pkt_count`.
- `pkt_size` changes mid-packet take effect at the next packet only.
- `clear`, or `reset_n` low:
  - empties the FIFO and output register;
  - FSM to IDLE;
  - `beat_cnt`, `pkt_count`, `overflow` to 0.
  - A partially emitted packet is abandoned with no tlast emitted.
- `clear` has priority over a simultaneous write or handshake.
- Pointers wrap modulo DEPTH-1 storage entries plus the output register; `count` never exceeds DEPTH.

## Timing
- Reset values (held while `reset_n` low):
  - `full_n=0`, `o_tvalid=0`, `o_tlast=0`, `o_tdata=0`, `pkt_count=0`, `overflow=0`.
  - `full_n` rises on the first edge after `reset_n` deasserts, and one cycle after `clear`.
- Latency: a sample accepted at edge N into an empty block shows `o_tvalid=1` after edge N+1 (one cycle, no combinational `din`→`o_tdata` path).
- Throughput: one beat per clock sustained with `write` and `o_tready` continuously high; no bubbles after the first beat.
- No combinational path from `o_tready` to `full_n` or from `write` to `o_tvalid`.

## Test plan
- Basic framing:
  - Stimulus: `pkt_size=4`, write 0x0001..0x0008 back-to-back, `o_tready=1`.
  - Response: 8 beats, `o_tdata=0x00000001..0x00000008` in order, tlast on beats 4 and 8, `pkt_count=2`, `overflow=0`.
- Backpressure and overflow:
  - Stimulus: `o_tready=0`, 20 consecutive writes 0x0010..0x0023.
  - Response: `full_n` falls after 16 accepted; the 4 excess writes are dropped and `overflow=1`.
  - After raising `o_tready`: exactly 0x0010..0x001F is emitted and `full_n` returns to 1.
- Mid-packet size change:
  - Stimulus: `pkt_size=3`, after the first beat set `pkt_size=5`, stream 8 samples.
  - Response: tlast on beats 3 and 8, `pkt_count=2`.
- Zero size:
  - Stimulus: `pkt_size=0`, 3 samples.
  - Response: every beat has tlast, `pkt_count=3`.
- Clear and reset mid-packet:
  - Stimulus: `pkt_size=8`, emit 3 beats, pulse `clear` with 4 samples buffered.
  - Response: `o_tvalid=0` next cycle, `pkt_count=0`, buffered samples discarded.
  - Repeat with `reset_n` asserted asynchronously between edges: outputs go to reset values immediately, without waiting for a clock edge.
  - After either, the next sample starts a fresh packet with tlast on its 8th beat.
- Throughput:
  - Stimulus: 64 back-to-back writes, `o_tready=1`, `pkt_size=16`.
  - Response: `o_tvalid` high for 64 consecutive cycles starting one cycle after the first write, tlast every 16th beat.
  - Randomized `o_tready` gaps preserve order and tdata/tlast stability while stalled.
